// File: rtl/mtc_link_tx_pkg.sv
// Shared constants and types for the MTC-to-sector-logic link transmitter.
//   MTC_PKT_WIDTH_DEF  : default MTC packet width (MTC2SL packet length)
//   LINK_FRAME_LEN     : default clocks per link frame (one BX)
//   LINK_MAX_PER_FRAME : default packet budget per link frame
//   link_state_e       : output FSM state
package mtc_link_tx_pkg;

  localparam int unsigned MTC2SL_PKT_LEN     = 128;
  localparam int unsigned MTC_PKT_WIDTH_DEF  = MTC2SL_PKT_LEN;
  localparam int unsigned LINK_FRAME_LEN     = 8;
  localparam int unsigned LINK_MAX_PER_FRAME = 3;

  typedef enum logic {
    LINK_IDLE = 1'b0,
    LINK_HOLD = 1'b1
  } link_state_e;

endpackage

// File: rtl/mtc_link_tx_fifo.sv
// mtc_link_fifo: synchronous packet FIFO.
//   clock, rst      : clock and synchronous active-high reset (empties the FIFO)
//   push, wr_data   : write request; ignored while full
//   pop             : read request; ignored while empty
//   rd_data         : head entry, valid while !empty; the consumer registers it on pop
//   full, empty     : occupancy flags from the current (pre-edge) count
//   count           : occupancy, one bit wider than the pointers so full != empty
module mtc_link_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers/count define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mtc_link_tx.sv
// mtc_link_tx: buffers formatted MTC packets and drains them onto the
// sector-logic link, at most MAX_PER_FRAME loads per FRAME_LEN-clock frame.
//   clock, rst          : clock, synchronous active-high reset
//   mtc_in, mtc_in_valid: packet input, no backpressure
//   link_data/valid     : link output register and its valid
//   link_ready          : link accepts link_data this cycle
//   frame_start         : frame counter is 0
//   fifo_count          : FIFO occupancy
//   drop_count          : packets dropped on full FIFO, saturating
//   overflow            : sticky drop flag
// Optional: define MTC_LINK_TX_STATS_EN to add max_occ (fifo_count high-watermark).
module mtc_link_tx
  import mtc_link_tx_pkg::*;
#(
  parameter int unsigned MTC_PKT_WIDTH = MTC_PKT_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned FRAME_LEN     = LINK_FRAME_LEN,
  parameter int unsigned MAX_PER_FRAME = LINK_MAX_PER_FRAME
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [MTC_PKT_WIDTH-1:0]      mtc_in,
  input  logic                          mtc_in_valid,
  output logic [MTC_PKT_WIDTH-1:0]      link_data,
  output logic                          link_valid,
  input  logic                          link_ready,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count,
  output logic                          overflow
`ifdef MTC_LINK_TX_STATS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   max_occ
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned SC_W  = $clog2(MAX_PER_FRAME + 1);
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [SC_W-1:0] SENT_MAX   = SC_W'(MAX_PER_FRAME);

  link_state_e              state_q, state_d;
  logic [MTC_PKT_WIDTH-1:0] link_data_q, link_data_d;
  logic [FC_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic [SC_W-1:0]          sent_cnt_q, sent_cnt_d;
  logic [15:0]              drop_count_q, drop_count_d;
  logic                     overflow_q, overflow_d;

  logic                     fifo_full, fifo_empty;
  logic [MTC_PKT_WIDTH-1:0] fifo_rd_data;
  logic [CNT_W-1:0]         fifo_cnt;
  logic                     can_load, load, drop, frame_last;

  mtc_link_fifo #(
    .WIDTH (MTC_PKT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .push    (mtc_in_valid),
    .wr_data (mtc_in),
    .pop     (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    frame_last  = (frame_cnt_q == FRAME_LAST);
    can_load    = !fifo_empty && (sent_cnt_q < SENT_MAX);
    load        = 1'b0;
    state_d     = state_q;
    link_data_d = link_data_q;

    // In HOLD a handshake and a fresh load share one edge, giving back-to-back output.
    case (state_q)
      LINK_IDLE: begin
        if (can_load) begin
          load    = 1'b1;
          state_d = LINK_HOLD;
        end
      end
      LINK_HOLD: begin
        if (link_ready) begin
          if (can_load) load = 1'b1;
          else          state_d = LINK_IDLE;
        end
      end
      default: state_d = LINK_IDLE;
    endcase

    if (load) link_data_d = fifo_rd_data;

    frame_cnt_d = frame_last ? '0 : frame_cnt_q + FC_W'(1);
    // A load in the last frame cycle is charged to the frame that is ending.
    sent_cnt_d  = frame_last ? '0 : sent_cnt_q + SC_W'(load);

    drop         = mtc_in_valid && fifo_full;
    drop_count_d = (drop && (drop_count_q != '1)) ? drop_count_q + 16'd1 : drop_count_q;
    overflow_d   = overflow_q || drop;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= LINK_IDLE;
      link_data_q  <= '0;
      frame_cnt_q  <= '0;
      sent_cnt_q   <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_data_q  <= link_data_d;
      frame_cnt_q  <= frame_cnt_d;
      sent_cnt_q   <= sent_cnt_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign link_data   = link_data_q;
  assign link_valid  = (state_q == LINK_HOLD);
  assign frame_start = (frame_cnt_q == '0);
  assign fifo_count  = fifo_cnt;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;

`ifdef MTC_LINK_TX_STATS_EN
  logic [CNT_W-1:0] max_occ_q, max_occ_d;

  always_comb begin
    max_occ_d = (fifo_cnt > max_occ_q) ? fifo_cnt : max_occ_q;
  end

  always_ff @(posedge clock) begin
    if (rst) max_occ_q <= '0;
    else     max_occ_q <= max_occ_d;
  end

  assign max_occ = max_occ_q;
`endif

endmodule

// File: tb/tb_mtc_link_tx.sv
`timescale 1ns/1ps
module tb_mtc_link_tx;

  localparam int unsigned W     = 128;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FLEN  = 8;

  logic                 clock = 1'b0;
  logic                 rst = 1'b1;
  logic [W-1:0]         mtc_in = '0;
  logic                 mtc_in_valid = 1'b0;
  logic [W-1:0]         link_data;
  logic                 link_valid;
  logic                 link_ready = 1'b1;
  logic                 frame_start;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]          drop_count;
  logic                 overflow;
`ifdef MTC_LINK_TX_STATS_EN
  logic [$clog2(DEPTH):0] max_occ;
`endif

  mtc_link_tx #(
    .MTC_PKT_WIDTH (W),
    .FIFO_DEPTH    (DEPTH),
    .FRAME_LEN     (FLEN),
    .MAX_PER_FRAME (3)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .mtc_in       (mtc_in),
    .mtc_in_valid (mtc_in_valid),
    .link_data    (link_data),
    .link_valid   (link_valid),
    .link_ready   (link_ready),
    .frame_start  (frame_start),
    .fifo_count   (fifo_count),
    .drop_count   (drop_count),
    .overflow     (overflow)
`ifdef MTC_LINK_TX_STATS_EN
    ,
    .max_occ      (max_occ)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every link handshake must match the next expected packet.
  always @(negedge clock) begin
    if (!rst && link_valid && link_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL link_unexpected: got %0h expected none", link_data);
      end else begin
        check("link_data", link_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frame_start(input string name);
    int unsigned k = 0;
    while (!frame_start && k < 2 * FLEN) begin
      tick();
      k++;
    end
    check(name, frame_start, 1);
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned k = 0;
    while ((exp_q.size() != 0 || link_valid) && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  bit t2_pat[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_link_valid", link_valid, 0);
    check("rst_link_data", link_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_start", frame_start, 1);
    rst = 1'b0;
    tick();
    tick();

    // Test 1: single packet, two-edge latency
    link_ready = 1'b1;
    mtc_in = 128'hA5;
    mtc_in_valid = 1'b1;
    exp_q.push_back(128'hA5);
    tick();
    mtc_in_valid = 1'b0;
    check("t1_valid_n", link_valid, 0);
    check("t1_count_n", fifo_count, 1);
    tick();
    check("t1_valid_n1", link_valid, 1);
    check("t1_data_n1", link_data, 128'hA5);
    tick();
    check("t1_valid_n2", link_valid, 0);

    // Test 2: 5 packets at frame start, budget of 3 per frame
    repeat (3) tick();
    wait_frame_start("t2_align");
    for (int k = 0; k < 11; k++) begin
      if (k < 5) begin
        mtc_in = 128'h200 + W'(k);
        mtc_in_valid = 1'b1;
        exp_q.push_back(128'h200 + W'(k));
      end else begin
        mtc_in_valid = 1'b0;
      end
      tick();
      check($sformatf("t2_valid_c%0d", k + 1), link_valid, t2_pat[k]);
      if (k == 7) check("t2_frame1_start", frame_start, 1);
    end
    wait_drain("t2_drain", 50);

    // Test 3: link stalled, 20 packets -> 16 in FIFO, 1 held, 3 dropped
    repeat (4) tick();
    link_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      mtc_in = 128'h300 + W'(k);
      mtc_in_valid = 1'b1;
      if (k < 17) exp_q.push_back(128'h300 + W'(k));
      tick();
    end
    mtc_in_valid = 1'b0;
    check("t3_fifo_count", fifo_count, 16);
    check("t3_drop_count", drop_count, 3);
    check("t3_overflow", overflow, 1);
    check("t3_link_valid", link_valid, 1);
    link_ready = 1'b1;
    wait_drain("t3_drain", 300);
    check("t3_fifo_empty", fifo_count, 0);
    check("t3_drop_hold", drop_count, 3);

    // Test 4: full FIFO, write and handshake in the same cycle
    repeat (2) tick();
    link_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      mtc_in = 128'h400 + W'(k);
      mtc_in_valid = 1'b1;
      exp_q.push_back(128'h400 + W'(k));
      tick();
    end
    mtc_in_valid = 1'b0;
    check("t4_full", fifo_count, 16);
    wait_frame_start("t4_align");
    mtc_in = 128'hDEAD;
    mtc_in_valid = 1'b1;
    link_ready = 1'b1;
    tick();
    mtc_in_valid = 1'b0;
    check("t4_fifo_count", fifo_count, 15);
    check("t4_drop_count", drop_count, 4);
    check("t4_overflow", overflow, 1);
    wait_drain("t4_drain", 300);

    // Test 5: reset mid-transfer discards everything
    repeat (2) tick();
    link_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mtc_in = 128'h500 + W'(k);
      mtc_in_valid = 1'b1;
      tick();
    end
    mtc_in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!(link_valid && fifo_count == 4)) tick();
    end
    check("t5_setup_count", fifo_count, 4);
    check("t5_setup_valid", link_valid, 1);
    rst = 1'b1;
    tick();
    check("t5_link_valid", link_valid, 0);
    check("t5_link_data", link_data, 0);
    check("t5_fifo_count", fifo_count, 0);
    check("t5_drop_count", drop_count, 0);
    check("t5_overflow", overflow, 0);
    rst = 1'b0;
    link_ready = 1'b1;
    repeat (4) tick();
    check("t5_post_valid", link_valid, 0);

`ifdef MTC_LINK_TX_STATS_EN
    // Test 6: high-watermark of fifo_count
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_max_rst", max_occ, 0);
    link_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mtc_in = 128'h600 + W'(k);
      mtc_in_valid = 1'b1;
      exp_q.push_back(128'h600 + W'(k));
      tick();
    end
    mtc_in_valid = 1'b0;
    repeat (2) tick();
    check("t6_fill_count", fifo_count, 7);
    link_ready = 1'b1;
    wait_drain("t6_drain", 100);
    repeat (2) tick();
    check("t6_max_occ", max_occ, 7);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
